// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, functs, FSM states,
// instruction classes and datapath select values.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_JR     = 6'h08;
    localparam logic [5:0] FN_ADDU   = 6'h21;
    localparam logic [5:0] FN_SUBU   = 6'h23;
    localparam logic [5:0] FN_SLT    = 6'h2A;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_e;

    // Instruction classes select the path the FSM takes after EXEC.
    typedef enum logic [2:0] {
        CLS_ILLEGAL = 3'd0,
        CLS_ALU     = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_JUMP    = 3'd4,
        CLS_LINK    = 3'd5,
        CLS_BLTZAL  = 3'd6
    } instr_class_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_OR  = 2'd2,
        ALU_SLT = 2'd3
    } alu_ctl_e;

    typedef enum logic [2:0] {
        SRC_ALU  = 3'd0,
        SRC_MEM  = 3'd1,
        SRC_ZERO = 3'd2,
        SRC_ONE  = 3'd3,
        SRC_PC   = 3'd4
    } reg_src_e;

    typedef enum logic [1:0] {
        DST_RD       = 2'd0,
        DST_RT       = 2'd1,
        DST_OVERFLOW = 2'd2,
        DST_NPC      = 2'd3
    } reg_dst_e;

    localparam logic ALU_SRC_REG = 1'b0;
    localparam logic ALU_SRC_EXT = 1'b1;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: maps opcode/funct and ALU flags onto an
// instruction class and the datapath select lines.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       positive,
    input  logic       overflow,
    output logic [2:0] class_code,
    output logic [1:0] alu_ctl,
    output logic       ext_op,
    output logic       alu_src,
    output logic       npc_sel,
    output logic       j_ctl,
    output logic       jr_ctl,
    output logic       bltzal,
    output logic [2:0] reg_src,
    output logic [1:0] reg_dst
);

    always_comb begin
        class_code = CLS_ILLEGAL;
        alu_ctl    = ALU_ADD;
        ext_op     = 1'b0;
        alu_src    = ALU_SRC_REG;
        npc_sel    = 1'b0;
        j_ctl      = 1'b0;
        jr_ctl     = 1'b0;
        bltzal     = 1'b0;
        reg_src    = SRC_ALU;
        reg_dst    = DST_RD;

        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: class_code = CLS_ALU;
                    FN_SUBU: begin
                        class_code = CLS_ALU;
                        alu_ctl    = ALU_SUB;
                    end
                    FN_SLT: begin
                        class_code = CLS_ALU;
                        alu_ctl    = ALU_SLT;
                    end
                    FN_JR: begin
                        class_code = CLS_JUMP;
                        jr_ctl     = 1'b1;
                    end
                    default: class_code = CLS_ILLEGAL;
                endcase
            end
            // Branch taken when the operand is strictly negative.
            OP_REGIMM: begin
                class_code = CLS_BLTZAL;
                bltzal     = 1'b1;
                ext_op     = 1'b1;
                npc_sel    = ~positive & ~zero;
                reg_src    = SRC_PC;
                reg_dst    = DST_NPC;
            end
            OP_J: begin
                class_code = CLS_JUMP;
                j_ctl      = 1'b1;
            end
            OP_JAL: begin
                class_code = CLS_LINK;
                j_ctl      = 1'b1;
                reg_src    = SRC_PC;
                reg_dst    = DST_NPC;
            end
            OP_BEQ: begin
                class_code = CLS_JUMP;
                alu_ctl    = ALU_SUB;
                ext_op     = 1'b1;
                npc_sel    = zero;
            end
            // An overflowing addi records a one in the overflow register instead of rt.
            OP_ADDI: begin
                class_code = CLS_ALU;
                alu_src    = ALU_SRC_EXT;
                ext_op     = 1'b1;
                reg_src    = overflow ? SRC_ONE : SRC_ALU;
                reg_dst    = overflow ? DST_OVERFLOW : DST_RT;
            end
            OP_ORI, OP_LUI: begin
                class_code = CLS_ALU;
                alu_ctl    = ALU_OR;
                alu_src    = ALU_SRC_EXT;
                reg_dst    = DST_RT;
            end
            OP_LW: begin
                class_code = CLS_LOAD;
                alu_src    = ALU_SRC_EXT;
                ext_op     = 1'b1;
                reg_src    = SRC_MEM;
                reg_dst    = DST_RT;
            end
            OP_SW: begin
                class_code = CLS_STORE;
                alu_src    = ALU_SRC_EXT;
                ext_op     = 1'b1;
            end
            default: class_code = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset controller: FETCH/DECODE/EXEC/MEM/WB sequencing.
// Define CTRL_INSTR_CNT_EN to add the 32-bit retired-instruction counter instr_cnt.
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        positive,
    input  logic        overflow,
    input  logic        mem_ready,
    output logic [1:0]  alu_ctl,
    output logic        ext_op,
    output logic        alu_src,
    output logic        npc_sel,
    output logic        j_ctl,
    output logic        jr_ctl,
    output logic        bltzal,
    output logic        mem_write,
    output logic        reg_write,
    output logic [2:0]  reg_src,
    output logic [1:0]  reg_dst,
    output logic        pc_write,
    output logic        ir_write,
    output logic        illegal
`ifdef CTRL_INSTR_CNT_EN
    ,
    output logic [31:0] instr_cnt
`endif
);

    state_e       state;
    instr_class_e cls;
    logic [2:0]   class_code;
    logic [1:0]   dec_alu_ctl;
    logic         dec_ext_op;
    logic         dec_alu_src;
    logic         dec_npc_sel;
    logic         dec_j_ctl;
    logic         dec_jr_ctl;
    logic         dec_bltzal;
    logic [2:0]   dec_reg_src;
    logic [1:0]   dec_reg_dst;
    logic         link_taken;

    mc_decode u_decode (
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .positive   (positive),
        .overflow   (overflow),
        .class_code (class_code),
        .alu_ctl    (dec_alu_ctl),
        .ext_op     (dec_ext_op),
        .alu_src    (dec_alu_src),
        .npc_sel    (dec_npc_sel),
        .j_ctl      (dec_j_ctl),
        .jr_ctl     (dec_jr_ctl),
        .bltzal     (dec_bltzal),
        .reg_src    (dec_reg_src),
        .reg_dst    (dec_reg_dst)
    );

    assign cls        = instr_class_e'(class_code);
    assign link_taken = (cls == CLS_LINK) || (cls == CLS_BLTZAL && !positive && !zero);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= FETCH;
            illegal <= 1'b0;
        end else begin
            case (state)
                FETCH:  state <= DECODE;
                DECODE: begin
                    state <= EXEC;
                    if (cls == CLS_ILLEGAL)
                        illegal <= 1'b1;
                end
                EXEC: begin
                    case (cls)
                        CLS_LOAD, CLS_STORE: state <= MEM;
                        CLS_ALU:             state <= WB;
                        default:             state <= FETCH;
                    endcase
                end
                MEM: begin
                    if (mem_ready)
                        state <= (cls == CLS_LOAD) ? WB : FETCH;
                end
                WB:      state <= FETCH;
                default: state <= FETCH;
            endcase
        end
    end

    // Everything is forced low while reset is held so an aborted instruction has no side effect.
    always_comb begin
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        mem_write = 1'b0;
        alu_ctl   = '0;
        ext_op    = 1'b0;
        alu_src   = 1'b0;
        npc_sel   = 1'b0;
        j_ctl     = 1'b0;
        jr_ctl    = 1'b0;
        bltzal    = 1'b0;
        reg_src   = '0;
        reg_dst   = '0;
        if (rst) begin
            alu_ctl = dec_alu_ctl;
            ext_op  = dec_ext_op;
            alu_src = dec_alu_src;
            npc_sel = dec_npc_sel;
            j_ctl   = dec_j_ctl;
            jr_ctl  = dec_jr_ctl;
            bltzal  = dec_bltzal;
            reg_src = dec_reg_src;
            reg_dst = dec_reg_dst;
            case (state)
                FETCH: ir_write = 1'b1;
                EXEC: begin
                    if (cls != CLS_ALU && cls != CLS_LOAD && cls != CLS_STORE)
                        pc_write = 1'b1;
                    reg_write = link_taken;
                end
                MEM: begin
                    if (cls == CLS_STORE) begin
                        mem_write = 1'b1;
                        pc_write  = mem_ready;
                    end
                end
                WB: begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef CTRL_INSTR_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst)
            instr_cnt <= '0;
        else if (pc_write)
            instr_cnt <= instr_cnt + 32'd1;
    end
`endif

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: synchronous, active-low reset.
REQ-003 The block SHALL have the ports opcode and funct, input, 6 bits each: fields of the current instruction from the datapath.
REQ-004 The block SHALL have the ports zero, positive and overflow, input, 1 bit each: ALU flags from the datapath.
REQ-005 The block SHALL have the port mem_ready, input, 1 bit: data memory access complete this cycle.
REQ-006 The block SHALL have the port alu_ctl, output, 2 bits: datapath ALU operation select.
REQ-007 The block SHALL have the ports ext_op, alu_src, npc_sel, j_ctl, jr_ctl, bltzal, mem_write and reg_write, output, 1 bit each: datapath control lines.
REQ-008 The block SHALL have the port reg_src, output, 3 bits: register write-data select.
REQ-009 The block SHALL have the port reg_dst, output, 2 bits: register write-address select.
REQ-010 The block SHALL have the ports pc_write and ir_write, output, 1 bit each: PC update enable and instruction register load enable.
REQ-011 The block SHALL have the port illegal, output, 1 bit: sticky flag set on an unsupported instruction.

Function
REQ-012 The block SHALL implement the states FETCH, DECODE, EXEC, MEM and WB.
REQ-013 The FETCH state SHALL assert ir_write for one cycle and then go to DECODE.
REQ-014 The DECODE state SHALL go to EXEC.
REQ-015 In EXEC, beq, j, jal, jr and bltzal SHALL complete: assert pc_write with the branch and jump controls, then return to FETCH.
REQ-016 In EXEC, jal and bltzal SHALL also assert reg_write with reg_dst=NPC and reg_src=PC; bltzal SHALL write only when positive=0 and zero=0.
REQ-017 In EXEC, lw and sw SHALL go to MEM; addu, subu, slt, ori, lui and addi SHALL go to WB.
REQ-018 The MEM state SHALL hold, with mem_write asserted for sw, until mem_ready=1. Then sw SHALL assert pc_write and go to FETCH, and lw SHALL go to WB.
REQ-019 The WB state SHALL assert reg_write and pc_write for one cycle, then go to FETCH.
REQ-020 In WB, addi with overflow=1 SHALL write the value ONE to reg_dst=OVERFLOW and SHALL NOT write rt.
REQ-021 Instructions SHALL take these cycle counts: branch/jump 3, ALU 4, sw 4+N, lw 5+N, where N is the number of extra cycles spent waiting for mem_ready.
REQ-022 mem_write, reg_write, pc_write and ir_write SHALL be 0 in every state or case not listed above.
REQ-023 An unsupported opcode/funct in DECODE SHALL set illegal, assert pc_write in EXEC as a no-op, and return to FETCH.
REQ-024 illegal SHALL clear only on reset.
REQ-025 The datapath select outputs SHALL be combinational decodes of opcode/funct and state, stable throughout an instruction.

Reset
REQ-026 When rst=0 at a rising clk edge, the state SHALL become FETCH and illegal SHALL become 0.
REQ-027 During reset all write enables SHALL be 0 and all select outputs SHALL be 0.
REQ-028 A reset asserted mid-instruction, including during a MEM wait, SHALL abort that instruction with no register, memory or PC write.

Configuration
REQ-029 With CTRL_INSTR_CNT_EN defined, the block SHALL add a 32-bit output instr_cnt that increments on every cycle pc_write=1, resets to 0, and wraps from 0xFFFFFFFF to 0.
REQ-030 Without CTRL_INSTR_CNT_EN, the instr_cnt port and its counter SHALL be absent.

Structure
REQ-031 The shared defines file SHALL hold the opcode/funct constants, the state encodings and these select encodings: ALU ADD=0, SUB=1, OR=2, SLT=3; REG_SRC ALU=0, MEM=1, ZERO=2, ONE=3, PC=4; REG_DST RD=0, RT=1, OVERFLOW=2, NPC=3; ALU_SRC REG=0, EXT=1.
REQ-032 The block SHALL have one sub-module, mc_decode: a combinational instruction-class and select decoder; the state register and transitions SHALL stay in mc_ctrl.

Verification
REQ-033 Bench: addu (opcode 0, funct 0x21) -> FETCH, DECODE, EXEC, WB; one reg_write pulse with reg_dst=RD, pc_write in cycle 4.
REQ-034 Bench: lw (0x23) with mem_ready low for 3 cycles -> MEM held 4 cycles; reg_write with reg_src=MEM in cycle 8.
REQ-035 Bench: addi (0x08) with overflow=1 -> WB writes reg_dst=OVERFLOW with reg_src=ONE; no rt write.
REQ-036 Bench: bltzal (0x01) with positive=1, then with positive=0 and zero=0 -> no write in the first; in the second, a write to NPC with reg_src=PC and pc_write in cycle 3.
REQ-037 Bench: opcode 0x3F -> illegal=1 after DECODE, pc_write in EXEC, illegal persists until rst=0.
REQ-038 Bench: rst=0 during a MEM wait of sw -> no mem_write the next cycle, state FETCH; with CTRL_INSTR_CNT_EN, instr_cnt=0.
